// File: rtl/microwave_controller.sv
// -----------------------------------------------------------------------------
// microwave_controller
//
// Top-level sequencer for the microwave cook timer. It converts keypad strobes
// into digit-load pulses for the external BCD timer, divides the system clock
// into a once-per-second decrement pulse while cooking, drives the magnetron
// enable and reports completion. The BCD counters live outside this block;
// only their controls are generated here.
//
// Parameters
//   CLK_PER_SEC  clock cycles per countdown second (>= 2)
//
// Ports
//   clock         system clock, rising edge
//   clear         asynchronous active-high reset
//   key_valid     one-cycle keypad strobe
//   key_digit     keypad digit (values above 9 are ignored)
//   start, stop   one-cycle button strobes
//   door_closed   level, 1 = door shut
//   timer_zero    timer reports 0:00
//   timer_data    digit to shift into the timer
//   timer_loadn   active-low one-cycle load pulse
//   timer_enable  one-cycle decrement pulse
//   timer_clear   active-high timer clear (held in reset, then one-cycle)
//   mag_on        magnetron enable
//   done          cook finished
//   state         IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4
// -----------------------------------------------------------------------------
module microwave_controller #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_enable,
  output logic       timer_clear,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    count_reg, count_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          door_prev_reg;
  logic [3:0]    timer_data_reg, timer_data_next;
  logic          timer_loadn_reg, timer_loadn_next;
  logic          timer_enable_reg, timer_enable_next;
  logic          timer_clear_reg, timer_clear_next;
  logic          mag_on_reg, mag_on_next;
  logic          done_reg, done_next;

  logic key_ok;
  logic door_fall;
  logic presc_wrap;

  assign key_ok     = key_valid && (key_digit <= 4'd9);
  assign door_fall  = door_prev_reg && !door_closed;
  assign presc_wrap = (presc_reg == PRESC_MAX);

  always_comb begin
    state_next        = state_reg;
    count_next        = count_reg;
    presc_next        = presc_reg;
    timer_data_next   = timer_data_reg;
    timer_loadn_next  = 1'b1;
    timer_enable_next = 1'b0;
    timer_clear_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (key_ok) begin
          timer_data_next  = key_digit;
          timer_loadn_next = 1'b0;
          count_next       = 2'd1;
          state_next       = ST_SET;
        end
      end

      ST_SET: begin
        // stop beats start, and an accepted start beats a key in the same cycle
        if (stop) begin
          timer_clear_next = 1'b1;
          count_next       = 2'd0;
          state_next       = ST_IDLE;
        end else if (start && door_closed && !timer_zero) begin
          presc_next = '0;
          state_next = ST_COOK;
        end else if (key_ok && (count_reg < 2'd3)) begin
          timer_data_next  = key_digit;
          timer_loadn_next = 1'b0;
          count_next       = count_reg + 2'd1;
        end
      end

      ST_COOK: begin
        // The prescaler advances on every edge spent in COOK, including the
        // edge that leaves it, so the cycles before a pause and after the
        // resume add up to exactly one second between ticks.
        presc_next = presc_wrap ? '0 : presc_reg + 1'b1;
        if (timer_zero) begin
          state_next = ST_DONE;
        end else if (!door_closed || stop) begin
          state_next = ST_PAUSE;
        end
        // A tick falling on the edge that leaves COOK is dropped.
        timer_enable_next = presc_wrap && (state_next == ST_COOK);
      end

      ST_PAUSE: begin
        if (stop) begin
          timer_clear_next = 1'b1;
          count_next       = 2'd0;
          state_next       = ST_IDLE;
        end else if (start && door_closed) begin
          state_next = ST_COOK;
        end
      end

      ST_DONE: begin
        // Any key, valid or not, only acknowledges completion; it is not loaded.
        if (stop || key_valid || door_fall) begin
          timer_clear_next = 1'b1;
          count_next       = 2'd0;
          state_next       = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        count_next = 2'd0;
      end
    endcase

    mag_on_next = (state_next == ST_COOK);
    done_next   = (state_next == ST_DONE);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg        <= ST_IDLE;
      count_reg        <= 2'd0;
      presc_reg        <= '0;
      door_prev_reg    <= 1'b0;
      timer_data_reg   <= 4'd0;
      timer_loadn_reg  <= 1'b1;
      timer_enable_reg <= 1'b0;
      timer_clear_reg  <= 1'b1;
      mag_on_reg       <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      count_reg        <= count_next;
      presc_reg        <= presc_next;
      door_prev_reg    <= door_closed;
      timer_data_reg   <= timer_data_next;
      timer_loadn_reg  <= timer_loadn_next;
      timer_enable_reg <= timer_enable_next;
      timer_clear_reg  <= timer_clear_next;
      mag_on_reg       <= mag_on_next;
      done_reg         <= done_next;
    end
  end

  assign timer_data   = timer_data_reg;
  assign timer_loadn  = timer_loadn_reg;
  assign timer_enable = timer_enable_reg;
  assign timer_clear  = timer_clear_reg;
  assign mag_on       = mag_on_reg;
  assign done         = done_reg;
  assign state        = state_reg;

endmodule
